// File: rtl/decode_pkg.sv
// Shared encodings for the RV32 decode control stage: ALU codes, opcodes,
// immediate selectors, trap causes, FSM states and the registered bundle.
package decode_pkg;

  localparam logic [4:0] ALU_AND    = 5'd0;
  localparam logic [4:0] ALU_OR     = 5'd1;
  localparam logic [4:0] ALU_ADD    = 5'd2;
  localparam logic [4:0] ALU_SUB    = 5'd3;
  localparam logic [4:0] ALU_SLL    = 5'd4;
  localparam logic [4:0] ALU_SRL    = 5'd5;
  localparam logic [4:0] ALU_SRA    = 5'd6;
  localparam logic [4:0] ALU_XOR    = 5'd7;
  localparam logic [4:0] ALU_SLT    = 5'd9;
  localparam logic [4:0] ALU_SLTU   = 5'd10;
  localparam logic [4:0] ALU_PASSB  = 5'd11;
  localparam logic [4:0] ALU_MUL    = 5'd12;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  localparam logic [1:0] TRAP_ILLEGAL = 2'd0;
  localparam logic [1:0] TRAP_ECALL   = 2'd1;
  localparam logic [1:0] TRAP_EBREAK  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0] alu;
    logic       regwrite;
    logic       alusrc;
    logic       pcsrc_a;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic [2:0] imm_sel;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] func3;
    logic       illegal;
    logic [1:0] trap_cause;
  } bundle_t;

  function automatic bundle_t bundle_reset();
    bundle_t b;
    b     = '0;
    b.alu = ALU_ADD;
    return b;
  endfunction

  // func3 -> ALU op shared by OP and OP-IMM when func7 is the base encoding
  function automatic logic [4:0] base_alu(input logic [2:0] f3);
    logic [4:0] r;
    case (f3)
      3'b000:  r = ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_ctrl_comb.sv
// Pure combinational RV32I(+M) instruction decoder producing ALU/datapath
// control, the illegal flag and the trap classification.
module decode_ctrl_comb
  import decode_pkg::*;
#(
  parameter bit ENABLE_M      = 1'b1,
  parameter bit ENABLE_SYSTEM = 1'b1
) (
  input  logic [31:0] i_instr,
  output logic [4:0]  o_alu,
  output logic        o_regwrite,
  output logic        o_alusrc,
  output logic        o_pcsrc_a,
  output logic        o_memread,
  output logic        o_memwrite,
  output logic        o_branch,
  output logic        o_jump,
  output logic [2:0]  o_imm_sel,
  output logic        o_illegal,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause
);

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_ill;
  logic       w_sys;

  assign w_op = i_instr[6:0];
  assign w_f3 = i_instr[14:12];
  assign w_f7 = i_instr[31:25];

  always_comb begin
    o_alu        = ALU_ADD;
    o_regwrite   = 1'b0;
    o_alusrc     = 1'b0;
    o_pcsrc_a    = 1'b0;
    o_memread    = 1'b0;
    o_memwrite   = 1'b0;
    o_branch     = 1'b0;
    o_jump       = 1'b0;
    o_imm_sel    = IMM_NONE;
    o_trap_cause = TRAP_ILLEGAL;
    w_ill        = 1'b0;
    w_sys        = 1'b0;

    case (w_op)
      OPC_OP: begin
        o_regwrite = 1'b1;
        case (w_f7)
          F7_BASE: o_alu = base_alu(w_f3);
          F7_ALT: begin
            if (w_f3 == 3'b000)      o_alu = ALU_SUB;
            else if (w_f3 == 3'b101) o_alu = ALU_SRA;
            else                     w_ill = 1'b1;
          end
          F7_MULDIV: begin
            if (ENABLE_M) o_alu = ALU_MUL + {2'b00, w_f3};
            else          w_ill = 1'b1;
          end
          default: w_ill = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        o_regwrite = 1'b1;
        o_alusrc   = 1'b1;
        o_imm_sel  = IMM_I;
        o_alu      = base_alu(w_f3);
        // func7 is only meaningful for the shift-immediate forms
        if (w_f3 == 3'b001 && w_f7 != F7_BASE) w_ill = 1'b1;
        if (w_f3 == 3'b101) begin
          if (w_f7 == F7_ALT)       o_alu = ALU_SRA;
          else if (w_f7 != F7_BASE) w_ill = 1'b1;
        end
      end
      OPC_LOAD: begin
        o_regwrite = 1'b1;
        o_memread  = 1'b1;
        o_alusrc   = 1'b1;
        o_imm_sel  = IMM_I;
        if (w_f3 == 3'b011 || w_f3[2:1] == 2'b11) w_ill = 1'b1;
      end
      OPC_STORE: begin
        o_memwrite = 1'b1;
        o_alusrc   = 1'b1;
        o_imm_sel  = IMM_S;
        if (w_f3 > 3'b010) w_ill = 1'b1;
      end
      OPC_BRANCH: begin
        o_branch  = 1'b1;
        o_imm_sel = IMM_B;
        case (w_f3[2:1])
          2'b00:   o_alu = ALU_SUB;
          2'b01:   w_ill = 1'b1;
          2'b10:   o_alu = ALU_SLT;
          default: o_alu = ALU_SLTU;
        endcase
      end
      OPC_JAL: begin
        o_jump     = 1'b1;
        o_regwrite = 1'b1;
        o_pcsrc_a  = 1'b1;
        o_alusrc   = 1'b1;
        o_imm_sel  = IMM_J;
      end
      OPC_JALR: begin
        o_jump     = 1'b1;
        o_regwrite = 1'b1;
        o_pcsrc_a  = 1'b1;
        o_alusrc   = 1'b1;
        o_imm_sel  = IMM_I;
        if (w_f3 != 3'b000) w_ill = 1'b1;
      end
      OPC_LUI: begin
        o_regwrite = 1'b1;
        o_alusrc   = 1'b1;
        o_imm_sel  = IMM_U;
        o_alu      = ALU_PASSB;
      end
      OPC_AUIPC: begin
        o_regwrite = 1'b1;
        o_alusrc   = 1'b1;
        o_pcsrc_a  = 1'b1;
        o_imm_sel  = IMM_U;
      end
      OPC_SYSTEM: begin
        if (!ENABLE_SYSTEM) begin
          w_ill = 1'b1;
        end else if (i_instr == INSTR_ECALL) begin
          w_sys        = 1'b1;
          o_trap_cause = TRAP_ECALL;
        end else if (i_instr == INSTR_EBREAK) begin
          w_sys        = 1'b1;
          o_trap_cause = TRAP_EBREAK;
        end else begin
          w_ill = 1'b1;
        end
      end
      default: w_ill = 1'b1;
    endcase

    if (w_ill || w_sys) begin
      o_regwrite = 1'b0;
      o_memread  = 1'b0;
      o_memwrite = 1'b0;
      o_branch   = 1'b0;
      o_jump     = 1'b0;
    end
    if (w_ill) o_trap_cause = TRAP_ILLEGAL;
  end

  assign o_illegal = w_ill;
  assign o_trap    = w_ill | w_sys;

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode stage: valid/ready handshake, EMPTY/FULL/TRAP FSM and
// output registers around the combinational decoder.
module decode_ctrl_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter bit          ENABLE_M      = 1'b1,
  parameter bit          ENABLE_SYSTEM = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      alu_control,
  output logic            regwrite,
  output logic            alusrc,
  output logic            pcsrc_a,
  output logic            memread,
  output logic            memwrite,
  output logic            branch,
  output logic            jump,
  output logic [2:0]      imm_sel,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      func3_out,
  output logic            illegal,
  output logic            trap_req,
  output logic [1:0]      trap_cause,
  input  logic            trap_ack
);

  state_t          r_state;
  state_t          w_state_nxt;
  bundle_t         r_bun;
  bundle_t         w_dec;
  logic [XLEN-1:0] r_pc;
  logic            w_dec_trap;
  logic            w_in_ready;
  logic            w_accept;

  decode_ctrl_comb #(
    .ENABLE_M      (ENABLE_M),
    .ENABLE_SYSTEM (ENABLE_SYSTEM)
  ) u_dec (
    .i_instr      (in_instr),
    .o_alu        (w_dec.alu),
    .o_regwrite   (w_dec.regwrite),
    .o_alusrc     (w_dec.alusrc),
    .o_pcsrc_a    (w_dec.pcsrc_a),
    .o_memread    (w_dec.memread),
    .o_memwrite   (w_dec.memwrite),
    .o_branch     (w_dec.branch),
    .o_jump       (w_dec.jump),
    .o_imm_sel    (w_dec.imm_sel),
    .o_illegal    (w_dec.illegal),
    .o_trap       (w_dec_trap),
    .o_trap_cause (w_dec.trap_cause)
  );

  assign w_dec.rd    = in_instr[11:7];
  assign w_dec.rs1   = in_instr[19:15];
  assign w_dec.rs2   = in_instr[24:20];
  assign w_dec.func3 = in_instr[14:12];

  always_comb begin
    w_in_ready  = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: w_in_ready = 1'b1;
      ST_FULL:  w_in_ready = out_ready;
      default:  w_in_ready = 1'b0;
    endcase
    if (flush || rst) w_in_ready = 1'b0;
    w_accept = in_valid & w_in_ready;

    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = w_dec_trap ? ST_TRAP : ST_FULL;
      ST_FULL: begin
        if (w_accept)       w_state_nxt = w_dec_trap ? ST_TRAP : ST_FULL;
        else if (out_ready) w_state_nxt = ST_EMPTY;
      end
      ST_TRAP:  if (trap_ack) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
    if (flush) w_state_nxt = ST_EMPTY;
  end

  // Bundle registers load only on accept; a drain to EMPTY leaves them as-is
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_pc    <= '0;
      r_bun   <= bundle_reset();
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        r_pc  <= '0;
        r_bun <= bundle_reset();
      end else if (w_accept) begin
        r_pc  <= in_pc;
        r_bun <= w_dec;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = (r_state != ST_EMPTY);
  assign trap_req    = (r_state == ST_TRAP);
  assign out_pc      = r_pc;
  assign alu_control = r_bun.alu;
  assign regwrite    = r_bun.regwrite;
  assign alusrc      = r_bun.alusrc;
  assign pcsrc_a     = r_bun.pcsrc_a;
  assign memread     = r_bun.memread;
  assign memwrite    = r_bun.memwrite;
  assign branch      = r_bun.branch;
  assign jump        = r_bun.jump;
  assign imm_sel     = r_bun.imm_sel;
  assign rd          = r_bun.rd;
  assign rs1         = r_bun.rs1;
  assign rs2         = r_bun.rs2;
  assign func3_out   = r_bun.func3;
  assign illegal     = r_bun.illegal;
  assign trap_cause  = r_bun.trap_cause;

endmodule
